// File: rtl/seq_64_bit_subtractor.sv
// seq_64_bit_subtractor: multi-cycle a - b, CHUNK bits per clock, LSB chunk
// first, start/done handshake. Optional signed overflow flag: SUB_OVERFLOW_FLAG_EN.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, diff, borrow
// (+ overflow when SUB_OVERFLOW_FLAG_EN is defined).
module seq_64_bit_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB_OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx;
  logic             bin;
  logic [CHUNK:0]   step;
  logic             accept;
  int               base;

  // One extra bit on the chunk difference: its top bit is the borrow out.
  always_comb begin
    base = int'(idx) * CHUNK;
    step = {1'b0, a_q[base +: CHUNK]}
         - {1'b0, b_q[base +: CHUNK]}
         - {{CHUNK{1'b0}}, bin};
  end

  assign accept = start && (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          diff[base +: CHUNK] <= step[CHUNK-1:0];
          bin <= step[CHUNK];
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            borrow <= step[CHUNK];
`ifdef SUB_OVERFLOW_FLAG_EN
            // Final chunk carries the result MSB.
            overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1])
                     && (step[CHUNK-1] != a_q[WIDTH-1]);
`endif
          end
        end
        default: begin
          done <= 1'b0;
          if (accept) begin
            state  <= RUN;
            a_q    <= a;
            b_q    <= b;
            idx    <= '0;
            bin    <= 1'b0;
            busy   <= 1'b1;
            borrow <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            overflow <= 1'b0;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_64_bit_subtractor.sv
// tb_seq_64_bit_subtractor: directed vectors plus a cycle-level reference
// model of the subtractor handshake, compared on every falling edge.
module tb_seq_64_bit_subtractor;

  localparam int NCHUNK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] diff;
  logic        borrow;
`ifdef SUB_OVERFLOW_FLAG_EN
  logic        overflow;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  seq_64_bit_subtractor dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow(borrow)
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: arithmetic result computed at accept, revealed
  // NCHUNK cycles later.
  logic        m_busy, m_done, m_borrow, m_ovf;
  logic [63:0] m_diff;
  logic [63:0] p_diff;
  logic        p_borrow, p_ovf;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_ovf    <= 1'b0;
      m_cnt    <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == NCHUNK - 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_diff   <= p_diff;
        m_borrow <= p_borrow;
        m_ovf    <= p_ovf;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        logic signed [64:0] s;
        s = $signed({a[63], a}) - $signed({b[63], b});
        p_diff   <= a - b;
        p_borrow <= (a < b);
        p_ovf    <= (s[64] != s[63]);
        m_busy   <= 1'b1;
        m_cnt    <= 0;
        m_borrow <= 1'b0;
        m_ovf    <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("borrow", 64'(borrow), 64'(m_borrow));
      if (busy && done) check("busy_and_done", 64'(1), 64'(0));
      if (!m_busy) check("diff", diff, m_diff);
`ifdef SUB_OVERFLOW_FLAG_EN
      check("overflow", 64'(overflow), 64'(m_ovf));
`endif
    end
  end

  // Wait at falling edges for done; cycles counted from current point.
  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 20 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [63:0] ta,
                        input logic [63:0] tb_v, input logic [63:0] ed,
                        input logic eb);
    int k;
    bit seen;
    @(posedge clk);
    #1;
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
    wait_done(seen);
    if (seen) begin
      check({name, "_latency"}, 64'(cyc - k), 64'(NCHUNK));
      check({name, "_diff"}, diff, ed);
      check({name, "_borrow"}, 64'(borrow), 64'(eb));
    end
  endtask

  initial begin
    bit seen;
    int t1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_diff", diff, 64'h0);
    check("rst_borrow", 64'(borrow), 64'(0));
    rst = 1'b0;

    run_op("basic", 64'h111, 64'h11, 64'h100, 1'b0);
    run_op("xchunk", 64'h0000_0000_0001_0000, 64'h1,
           64'h0000_0000_0000_FFFF, 1'b0);
    run_op("under", 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("equal", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h0, 1'b0);
    run_op("mid", 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001,
           64'h0000_FFFF_FFFF_FFFF, 1'b0);

    // start held high: back-to-back operations.
    @(posedge clk);
    #1;
    a = 64'd5;
    b = 64'd3;
    start = 1'b1;
    wait_done(seen);
    t1 = cyc;
    check("b2b_diff0", diff, 64'd2);
    wait_done(seen);
    check("b2b_interval", 64'(cyc - t1), 64'(NCHUNK + 1));
    check("b2b_diff1", diff, 64'd2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    a = 64'd9;
    wait_done(seen);
    check("b2b_inflight", diff, 64'd2);
    wait_done(seen);
    check("b2b_new_a", diff, 64'd6);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (NCHUNK + 2) @(posedge clk);
    #1;

    // Reset during RUN.
    a = 64'h111;
    b = 64'h11;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_diff", diff, 64'h0);
    check("abort_borrow", 64'(borrow), 64'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) check("abort_no_done", 64'(done), 64'(0));
    end
    run_op("after_abort", 64'h111, 64'h11, 64'h100, 1'b0);

`ifdef SUB_OVERFLOW_FLAG_EN
    run_op("ovf", 64'h8000_0000_0000_0000, 64'h1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    check("ovf_flag", 64'(overflow), 64'(1));
    run_op("noovf", 64'd5, 64'd3, 64'd2, 1'b0);
    check("noovf_flag", 64'(overflow), 64'(0));
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
